// File: rtl/sap_control_unit.sv
// Microcode sequencer for the 8-bit computer: step counter plus opcode decode into the 16-bit control word.
// Optional build macro CU_COND_JUMP_EN enables the conditional jumps JC/JZ; otherwise they decode as NOP.
module sap_control_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    input  logic        carry,
    input  logic        zero,
    output logic [15:0] ctrl,
    output logic [2:0]  step,
    output logic        halted
);

    localparam logic [15:0] CE  = 16'h0001;
    localparam logic [15:0] CO  = 16'h0002;
    localparam logic [15:0] J   = 16'h0004;
    localparam logic [15:0] MI  = 16'h0008;
    localparam logic [15:0] RI  = 16'h0010;
    localparam logic [15:0] RO  = 16'h0020;
    localparam logic [15:0] II  = 16'h0040;
    localparam logic [15:0] IO  = 16'h0080;
    localparam logic [15:0] AI  = 16'h0100;
    localparam logic [15:0] AO  = 16'h0200;
    localparam logic [15:0] EO  = 16'h0400;
    localparam logic [15:0] SU  = 16'h0800;
    localparam logic [15:0] BI  = 16'h1000;
    localparam logic [15:0] OI  = 16'h2000;
    localparam logic [15:0] FI  = 16'h4000;
    localparam logic [15:0] HLT = 16'h8000;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    step_t       step_reg, step_next;
    logic        halted_reg, halted_next;
    step_t       last_step;
    logic [15:0] word;

    always_ff @(posedge clk) begin
        if (rst) begin
            step_reg   <= T0;
            halted_reg <= 1'b0;
        end else begin
            step_reg   <= step_next;
            halted_reg <= halted_next;
        end
    end

    // Decode: fetch is opcode-independent; execute steps look at the opcode.
    always_comb begin
        word      = 16'h0000;
        last_step = T2;
        if (halted_reg) begin
            word = HLT;
        end else begin
            case (step_reg)
                T0: word = CO | MI;
                T1: word = RO | II | CE;
                default: begin
                    case (opcode)
                        4'h1: begin
                            last_step = T3;
                            if (step_reg == T2)      word = IO | MI;
                            else if (step_reg == T3) word = RO | AI;
                        end
                        4'h2, 4'h3: begin
                            last_step = T4;
                            if (step_reg == T2)      word = IO | MI;
                            else if (step_reg == T3) word = RO | BI;
                            else if (step_reg == T4)
                                word = EO | AI | FI | ((opcode == 4'h3) ? SU : 16'h0000);
                        end
                        4'h4: begin
                            last_step = T3;
                            if (step_reg == T2)      word = IO | MI;
                            else if (step_reg == T3) word = AO | RI;
                        end
                        4'h5: if (step_reg == T2) word = IO | AI;
                        4'h6: if (step_reg == T2) word = IO | J;
`ifdef CU_COND_JUMP_EN
                        4'h7: if (step_reg == T2 && carry) word = IO | J;
                        4'h8: if (step_reg == T2 && zero)  word = IO | J;
`endif
                        4'hE: if (step_reg == T2) word = AO | OI;
                        4'hF: if (step_reg == T2) word = HLT;
                        default: word = 16'h0000;
                    endcase
                end
            endcase
        end
    end

    // Sequencing: HLT freezes at T2; otherwise wrap after the instruction's last step.
    always_comb begin
        step_next   = step_reg;
        halted_next = halted_reg;
        if (!halted_reg) begin
            if (step_reg == T2 && opcode == 4'hF) begin
                halted_next = 1'b1;
            end else if (step_reg >= last_step) begin
                step_next = T0;
            end else begin
                step_next = step_t'(step_reg + 3'd1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_ctrl
            assign ctrl[gi] = word[gi] & ~rst;
        end
    endgenerate

    assign step   = step_reg;
    assign halted = halted_reg;

endmodule
